// File: rtl/load_store_unit.sv
// Load/store unit: turns one core memory operation into a single-beat bus transaction
// with byte-lane steering, load sign/zero extension and alignment/illegal-op checking.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUS_REQ  = 2'd1,
        BUS_WAIT = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t      state_r, state_next_s;
    logic        accept_s, reject_s;
    logic        we_r;
    logic [2:0]  op_r;
    logic [1:0]  addr_lo_r;
    logic        req_ready_r, rsp_valid_r, rsp_err_r;
    logic        bus_req_r, bus_we_r;
    logic [31:0] rsp_rdata_r, bus_addr_r, bus_wdata_r;
    logic [3:0]  bus_be_r;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
        case (op[1:0])
            2'b01:   misaligned = a[0];
            2'b10:   misaligned = (a != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] op, input logic [1:0] a);
        case (op[1:0])
            2'b00:   byte_enable = 4'b0001 << a;
            2'b01:   byte_enable = 4'b0011 << a;
            default: byte_enable = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [2:0] op, input logic [31:0] d);
        case (op[1:0])
            2'b00:   replicate = {4{d[7:0]}};
            2'b01:   replicate = {2{d[15:0]}};
            default: replicate = d;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] a,
                                            input logic [31:0] rdata);
        logic [31:0] lane;
        lane = rdata >> {a, 3'b000};
        case (op)
            3'b000:  extract = {{24{lane[7]}}, lane[7:0]};
            3'b001:  extract = {{16{lane[15]}}, lane[15:0]};
            3'b100:  extract = {24'd0, lane[7:0]};
            3'b101:  extract = {16'd0, lane[15:0]};
            default: extract = lane;
        endcase
    endfunction

    // Next-state decode; req_valid is only considered while IDLE.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        reject_s     = 1'b0;
        case (state_r)
            IDLE: begin
                accept_s = req_valid;
                reject_s = !op_legal(req_op) || misaligned(req_op, req_addr[1:0]);
                if (req_valid) state_next_s = reject_s ? RESP : BUS_REQ;
                else           state_next_s = IDLE;
            end
            BUS_REQ: begin
                if (bus_gnt) state_next_s = we_r ? RESP : BUS_WAIT;
                else         state_next_s = BUS_REQ;
            end
            BUS_WAIT: begin
                if (bus_rvalid) state_next_s = RESP;
                else            state_next_s = BUS_WAIT;
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, latched request, registered bus drive and held response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            we_r        <= 1'b0;
            op_r        <= 3'b000;
            addr_lo_r   <= 2'b00;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'd0;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'd0;
            bus_be_r    <= 4'd0;
            bus_wdata_r <= 32'd0;
        end else begin
            state_r     <= state_next_s;
            req_ready_r <= (state_next_s == IDLE);
            rsp_valid_r <= (state_next_s == RESP);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        we_r      <= req_we;
                        op_r      <= req_op;
                        addr_lo_r <= req_addr[1:0];
                        if (reject_s) begin
                            rsp_err_r   <= 1'b1;
                            rsp_rdata_r <= 32'd0;
                        end else begin
                            bus_req_r   <= 1'b1;
                            bus_we_r    <= req_we;
                            bus_addr_r  <= {req_addr[31:2], 2'b00};
                            bus_be_r    <= byte_enable(req_op, req_addr[1:0]);
                            bus_wdata_r <= replicate(req_op, req_wdata);
                        end
                    end
                end
                BUS_REQ: begin
                    if (bus_gnt) begin
                        bus_req_r   <= 1'b0;
                        bus_we_r    <= 1'b0;
                        bus_be_r    <= 4'd0;
                        bus_wdata_r <= 32'd0;
                        if (we_r) begin
                            rsp_err_r   <= 1'b0;
                            rsp_rdata_r <= 32'd0;
                        end
                    end
                end
                BUS_WAIT: begin
                    if (bus_rvalid) begin
                        rsp_err_r   <= 1'b0;
                        rsp_rdata_r <= extract(op_r, addr_lo_r, bus_rdata);
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign bus_req   = bus_req_r;
    assign bus_we    = bus_we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_be    = bus_be_r;
    assign bus_wdata = bus_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset corner cases and
// randomized operations checked cycle by cycle against an arithmetic reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n, req_valid, req_ready, req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        bus_req, bus_we, bus_gnt, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_rsp_rdata;
    logic        exp_rsp_err;
    logic        obs_breq;
    logic [3:0]  obs_be;
    logic [31:0] obs_wd, obs_addr;
    int          obs_lat;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gd;
        int          rd;
        logic [31:0] rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_bwd;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sizes in bytes, lanes by arithmetic.
    function automatic int m_size(input logic [2:0] op);
        return 1 << op[1:0];
    endfunction

    function automatic logic m_bad(input logic [2:0] op, input logic [31:0] addr);
        int a;
        a = int'(addr[1:0]);
        if (!(op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b1;
        return (a % m_size(op)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] op, input logic [31:0] addr);
        int v;
        v = ((1 << m_size(op)) - 1) << int'(addr[1:0]);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] wd);
        logic [31:0] r;
        int s;
        s = m_size(op);
        r = 32'd0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % s) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] addr,
                                           input logic [31:0] rd);
        logic [31:0] lane, mask, v;
        int s;
        s    = m_size(op);
        lane = rd >> (8 * int'(addr[1:0]));
        mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
        v    = lane & mask;
        if (!op[2] && s < 4 && (v & ((mask >> 1) + 32'd1)) != 32'd0) v = v | ~mask;
        return v;
    endfunction

    // One operation from handshake until the first IDLE cycle, checked every cycle.
    task automatic run_op(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input int gd, input int rd,
                          input logic [31:0] rdata);
        logic bad, in_breq, in_bwait;
        int   resp_k;
        bad    = m_bad(op, addr);
        resp_k = bad ? 1 : (we ? 2 + gd : 3 + gd + rd);
        obs_lat = 0;
        req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
        bus_gnt = 1'b0; bus_rvalid = 1'($urandom); bus_rdata = $urandom;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'($urandom); req_op = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        for (int k = 1; k <= resp_k + 1; k++) begin
            in_breq  = !bad && k <= 1 + gd;
            in_bwait = !bad && !we && k >= 2 + gd && k < resp_k;
            if (k == 1) begin
                obs_breq = bus_req; obs_be = bus_be; obs_wd = bus_wdata; obs_addr = bus_addr;
            end
            if (rsp_valid && obs_lat == 0) obs_lat = k;
            check("bus_req", 32'(bus_req), 32'(in_breq));
            check("bus_we", 32'(bus_we), 32'(in_breq && we));
            check("bus_be", 32'(bus_be), in_breq ? 32'(m_be(op, addr)) : 32'd0);
            if (in_breq) check("bus_addr", bus_addr, {addr[31:2], 2'b00});
            if (in_breq && we) check("bus_wdata", bus_wdata, m_wdata(op, wdata));
            else if (!in_breq) check("bus_wdata_idle", bus_wdata, 32'd0);
            check("req_ready", 32'(req_ready), 32'(k == resp_k + 1));
            check("rsp_valid", 32'(rsp_valid), 32'(k == resp_k));
            if (k == resp_k) begin
                exp_rsp_err   = bad;
                exp_rsp_rdata = (bad || we) ? 32'd0 : m_load(op, addr, rdata);
            end
            check("rsp_rdata", rsp_rdata, exp_rsp_rdata);
            check("rsp_err", 32'(rsp_err), 32'(exp_rsp_err));
            bus_gnt = in_breq && k == 1 + gd;
            if (in_bwait) begin
                bus_rvalid = (k == resp_k - 1);
                bus_rdata  = (k == resp_k - 1) ? rdata : $urandom;
            end else begin
                bus_rvalid = 1'($urandom);
                bus_rdata  = $urandom;
            end
            if (k <= resp_k) @(negedge clk);
        end
    endtask

    // Reset while stalled in BUS_REQ (where=0) or waiting for data (where=1).
    task automatic reset_mid(input int where);
        req_valid = 1'b1; req_we = 1'b0; req_op = 3'b010; req_addr = 32'h0000_0100;
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        if (where == 1) begin
            bus_gnt = 1'b1;
            @(negedge clk);
            bus_gnt = 1'b0;
        end
        check("busy_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_rsp_rdata = 32'd0; exp_rsp_err = 1'b0;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_be", 32'(bus_be), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        bus_rvalid = 1'b1; bus_rdata = 32'h55AA_55AA;
        @(negedge clk);
        bus_rvalid = 1'b0;
        check("late_rvalid_valid", 32'(rsp_valid), 32'd0);
        check("late_rvalid_ready", 32'(req_ready), 32'd1);
        check("late_rvalid_bus_req", 32'(bus_req), 32'd0);
        @(negedge clk);
        check("late_rvalid_valid2", 32'(rsp_valid), 32'd0);
        check("late_rvalid_rdata", rsp_rdata, 32'd0);
    endtask

    initial begin
        logic [2:0] legal_ops [5];
        logic [2:0] op;
        logic [31:0] addr;
        legal_ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        //          we    op      addr          wdata         gd rd rdata         be       bwd           rdata         err  lat
        tbl[0] = '{1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'h0,        4'b1000, 32'hABAB_ABAB, 32'h0,        1'b0, 2};
        tbl[1] = '{1'b0, 3'b000, 32'h0000_2002, 32'h0,         0, 0, 32'h0080_7F00, 4'b0100, 32'h0,        32'hFFFF_FF80, 1'b0, 3};
        tbl[2] = '{1'b0, 3'b101, 32'h0000_2002, 32'h0,         0, 0, 32'h0080_7F00, 4'b1100, 32'h0,        32'h0000_0080, 1'b0, 3};
        tbl[3] = '{1'b0, 3'b010, 32'h0000_3001, 32'h0,         0, 0, 32'h1111_1111, 4'b0000, 32'h0,        32'h0,        1'b1, 1};
        tbl[4] = '{1'b1, 3'b010, 32'h0000_4000, 32'h1234_5678, 5, 0, 32'h0,        4'b1111, 32'h1234_5678, 32'h0,        1'b0, 7};
        tbl[5] = '{1'b1, 3'b011, 32'h0000_4000, 32'h1234_5678, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1};
        tbl[6] = '{1'b0, 3'b010, 32'h0000_5004, 32'h0,         0, 2, 32'hDEAD_BEEF, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1'b0, 5};
        tbl[7] = '{1'b0, 3'b001, 32'h0000_6000, 32'h0,         1, 1, 32'h1234_8001, 4'b0011, 32'h0,        32'hFFFF_8001, 1'b0, 5};
        tbl[8] = '{1'b1, 3'b001, 32'h0000_7002, 32'h0000_BEEF, 0, 0, 32'h0,        4'b1100, 32'hBEEF_BEEF, 32'h0,        1'b0, 2};
        tbl[9] = '{1'b0, 3'b101, 32'h0000_7001, 32'h0,         0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1};

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_op = 3'b000;
        req_addr = 32'd0; req_wdata = 32'd0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        exp_rsp_rdata = 32'd0; exp_rsp_err = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_bus_req", 32'(bus_req), 32'd0);
        check("reset_bus_we", 32'(bus_we), 32'd0);
        check("reset_bus_be", 32'(bus_be), 32'd0);
        check("reset_bus_wdata", bus_wdata, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].we, tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].gd, tbl[i].rd,
                   tbl[i].rdata);
            check($sformatf("tbl%0d_latency", i), 32'(obs_lat), 32'(tbl[i].exp_lat));
            check($sformatf("tbl%0d_bus_req_seen", i), 32'(obs_breq), 32'(!tbl[i].exp_err));
            check($sformatf("tbl%0d_be", i), 32'(obs_be), 32'(tbl[i].exp_be));
            if (!tbl[i].exp_err)
                check($sformatf("tbl%0d_addr", i), obs_addr, {tbl[i].addr[31:2], 2'b00});
            if (tbl[i].we && !tbl[i].exp_err)
                check($sformatf("tbl%0d_bwdata", i), obs_wd, tbl[i].exp_bwd);
            check($sformatf("tbl%0d_rdata", i), rsp_rdata, tbl[i].exp_rdata);
            check($sformatf("tbl%0d_err", i), 32'(rsp_err), 32'(tbl[i].exp_err));
        end

        reset_mid(1);
        run_op(1'b0, 3'b100, 32'h0000_0203, 32'd0, 0, 0, 32'hC300_0000);
        reset_mid(0);

        for (int n = 0; n < 300; n++) begin
            op   = ($urandom_range(0, 7) == 0) ? 3'($urandom) : legal_ops[$urandom_range(0, 4)];
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            run_op(1'($urandom), op, addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
